// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam int   UART_CLKS_PER_BIT = 21;
   localparam logic UART_IDLE_LEVEL   = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing a one-cycle enable at the last count
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic clock_in,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // tick must not depend on clear: clear is derived from the accept that tick enables
   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - frame FSM driving start, data, parity and stop bits onto tx_out
module uart_tx_sequencer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clock_in,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int             BCW       = $clog2(DATA_BITS + 1);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
   localparam logic           PAR_ODD   = (PARITY_ODD != 0);
   localparam logic           PAR_EN    = (PARITY_EN != 0);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 parity_q, parity_d;
   logic                 tx_out_q, tx_out_d;
   logic                 tick;
   logic                 accept;

   assign frame_done = (state_q == STOP) && tick && (bit_cnt_q == LAST_STOP);
   assign tx_ready   = (state_q == IDLE) || frame_done;
   assign accept     = tx_valid && tx_ready;
   assign busy       = (state_q != IDLE);
   assign tx_out     = tx_out_q;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock_in(clock_in),
      .rst     (rst),
      .clear   (accept || (state_q == IDLE)),
      .tick    (tick)
   );

   // tx_out_d carries the level of the bit being entered, so tx_out changes on the bit edge
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      tx_out_d  = tx_out_q;
      case (state_q)
         IDLE: begin
            tx_out_d = UART_IDLE_LEVEL;
            if (accept) begin
               state_d   = START;
               shreg_d   = tx_data;
               parity_d  = (^tx_data) ^ PAR_ODD;
               bit_cnt_d = '0;
               tx_out_d  = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               tx_out_d  = shreg_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  if (PAR_EN) begin
                     state_d  = PARITY;
                     tx_out_d = parity_q;
                  end else begin
                     state_d  = STOP;
                     tx_out_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                  tx_out_d  = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_d   = STOP;
               bit_cnt_d = '0;
               tx_out_d  = 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  bit_cnt_d = '0;
                  if (accept) begin
                     state_d  = START;
                     shreg_d  = tx_data;
                     parity_d = (^tx_data) ^ PAR_ODD;
                     tx_out_d = 1'b0;
                  end else begin
                     state_d  = IDLE;
                     tx_out_d = UART_IDLE_LEVEL;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            tx_out_d = UART_IDLE_LEVEL;
         end
      endcase
   end

   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_out_q  <= UART_IDLE_LEVEL;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         tx_out_q  <= tx_out_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - scoreboard bench for uart_tx_sequencer (default, even and odd parity)
module tb_uart_tx_sequencer;
   localparam int CPB = 21;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       par;
      int         t;
      logic       b2b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] valid_v;
   logic [7:0] data_a [3];
   logic [2:0] ready_w, tx_out_w, busy_w, done_w;
   int         cyc = 0;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;

   logic       in_frame [3];
   int         start_c  [3];
   int         cnt      [3];
   int         last_done[3];
   logic [11:0] got     [3];
   logic       rdy_bad  [3];
   logic       gap_ok   [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_sequencer #(.CLKS_PER_BIT(CPB)) dut0 (
      .clock_in(clk), .rst(rst), .tx_data(data_a[0]), .tx_valid(valid_v[0]),
      .tx_ready(ready_w[0]), .tx_out(tx_out_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
   uart_tx_sequencer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
      .clock_in(clk), .rst(rst), .tx_data(data_a[1]), .tx_valid(valid_v[1]),
      .tx_ready(ready_w[1]), .tx_out(tx_out_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
   uart_tx_sequencer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
      .clock_in(clk), .rst(rst), .tx_data(data_a[2]), .tx_valid(valid_v[2]),
      .tx_ready(ready_w[2]), .tx_out(tx_out_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic mon_step(input int k);
      exp_t        e;
      logic [11:0] ex;
      logic [11:0] mask;
      int          nb;
      int          flen;
      if (!busy_w[k]) begin
         in_frame[k] = 1'b0;
         if (done_w[k]) check($sformatf("done_while_idle inst%0d", k), 1, 0);
         return;
      end
      if (!in_frame[k]) begin
         in_frame[k] = 1'b1;
         start_c[k]  = cyc;
         cnt[k]      = 0;
         got[k]      = '0;
         rdy_bad[k]  = 1'b0;
         gap_ok[k]   = (last_done[k] == cyc - 1);
      end
      if ((cnt[k] % CPB) == CPB / 2 && (cnt[k] / CPB) < 12) got[k][cnt[k] / CPB] = tx_out_w[k];
      if (done_w[k]) begin
         if (!ready_w[k]) rdy_bad[k] = 1'b1;
         if (q.size() == 0) begin
            check($sformatf("unexpected_frame inst%0d", k), 1, 0);
         end else begin
            e    = q.pop_front();
            flen = (k == 0) ? 10 * CPB : 11 * CPB;
            nb   = (k == 0) ? 10 : 11;
            ex   = '0;
            for (int i = 0; i < 8; i++) ex[1 + i] = e.data[i];
            if (k == 0) begin
               ex[9] = 1'b1;
            end else begin
               ex[9]  = e.par;
               ex[10] = 1'b1;
            end
            mask = 12'((1 << nb) - 1);
            check("frame_instance", k, e.inst);
            check($sformatf("frame_bits inst%0d data %02h", k, e.data), int'(got[k] & mask), int'(ex));
            check($sformatf("start_cycle inst%0d data %02h", k, e.data), start_c[k], e.t);
            check($sformatf("done_cycle inst%0d data %02h", k, e.data), cyc, e.t + flen - 1);
            check($sformatf("tx_ready_profile inst%0d data %02h", k, e.data), int'(rdy_bad[k]), 0);
            if (e.b2b) check($sformatf("b2b_no_gap data %02h", e.data), int'(gap_ok[k]), 1);
         end
         in_frame[k]  = 1'b0;
         last_done[k] = cyc;
      end else if (ready_w[k]) begin
         rdy_bad[k] = 1'b1;
      end
      cnt[k]++;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         in_frame[k]  = 1'b0;
         last_done[k] = -10;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) mon_step(k);
      end
   end

   task automatic send(input int k, input logic [7:0] d, input logic par, input logic b2b);
      int n = 0;
      @(negedge clk);
      valid_v[k] = 1'b1;
      data_a[k]  = d;
      while (!ready_w[k] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         check($sformatf("accept_timeout inst%0d", k), 1, 0);
      end else begin
         q.push_back('{inst: k, data: d, par: par, t: cyc + 1, b2b: b2b});
         @(posedge clk);
      end
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      @(negedge clk);
      valid_v[k] = 1'b0;
      while (busy_w[k] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) check($sformatf("idle_timeout inst%0d", k), 1, 0);
   endtask

   initial begin
      int bad;
      rst     = 1'b0;
      valid_v = '0;
      for (int k = 0; k < 3; k++) data_a[k] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_tx_out", int'(tx_out_w), 7);
      check("reset_tx_ready", int'(ready_w), 7);
      check("reset_busy", int'(busy_w), 0);
      rst = 1'b1;

      bad = 0;
      repeat (500) begin
         @(negedge clk);
         if (tx_out_w != 3'b111 || ready_w != 3'b111 || busy_w != 3'b000 || done_w != 3'b000) bad++;
      end
      check("idle_500_cycles_bad", bad, 0);

      send(0, 8'hA5, 1'b0, 1'b0);
      @(negedge clk);
      valid_v[0] = 1'b0;
      check("start_latency_tx_out", int'(tx_out_w[0]), 0);
      repeat (20) @(negedge clk);
      check("start_bit_last_cycle", int'(tx_out_w[0]), 0);
      @(negedge clk);
      check("data_bit0_first_cycle", int'(tx_out_w[0]), 1);
      wait_idle(0);

      send(1, 8'h07, 1'b1, 1'b0);
      wait_idle(1);
      send(2, 8'h07, 1'b0, 1'b0);
      wait_idle(2);
      send(1, 8'hA5, 1'b0, 1'b0);
      wait_idle(1);
      send(2, 8'h00, 1'b1, 1'b0);
      wait_idle(2);

      send(0, 8'h55, 1'b0, 1'b0);
      send(0, 8'h0F, 1'b0, 1'b1);
      wait_idle(0);

      send(0, 8'h3C, 1'b0, 1'b0);
      repeat (215) begin
         @(negedge clk);
         valid_v[0] = 1'b0;
         data_a[0]  = 8'($urandom);
      end
      wait_idle(0);

      send(0, 8'hFF, 1'b0, 1'b0);
      @(negedge clk);
      valid_v[0] = 1'b0;
      repeat (109) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midframe_reset_tx_out", int'(tx_out_w[0]), 1);
      check("midframe_reset_busy", int'(busy_w[0]), 0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      send(0, 8'h01, 1'b0, 1'b0);
      wait_idle(0);

      repeat (5) @(negedge clk);
      check("pending_frames", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
